// File: rtl/bridge_pkg.sv
// bridge_pkg: shared types and constants for the bus bridge transfer controller
package bridge_pkg;
    localparam int XFER_SEL_W = 3;
    localparam logic DIR_DOWN = 1'b1;
    localparam logic DIR_UP = 1'b0;
    typedef enum logic [1:0] {IDLE, DRIVE, LATCH} xfer_state_t;
    typedef struct packed {
        logic dir;
        logic [XFER_SEL_W-1:0] src;
        logic [XFER_SEL_W-1:0] dst;
    } xfer_req_t;
endpackage

// File: rtl/bridge_req_fifo.sv
// bridge_req_fifo: synchronous FIFO of transfer requests with full/empty flags
module bridge_req_fifo
    import bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  xfer_req_t wr_data,
    output xfer_req_t rd_data,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);
    xfer_req_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rd_data = mem[rd_ptr];
    // storage needs no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/bridge_xfer_ctrl.sv
// bridge_xfer_ctrl: queued DRIVE/LATCH sequencer for the bridge GOe/Dir controls (optional counter: BRIDGE_XFER_CNT_EN)
module bridge_xfer_ctrl
    import bridge_pkg::*;
#(
    parameter int SEL_W = XFER_SEL_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_dir,
    input  logic [SEL_W-1:0]    req_src,
    input  logic [SEL_W-1:0]    req_dst,
    output logic                GOe,
    output logic                Dir,
    output logic [2**SEL_W-1:0] src_oe,
    output logic [2**SEL_W-1:0] dst_ld,
    output logic                xfer_done,
    output logic                busy,
    output logic [CNT_W-1:0]    xfer_cnt
);
    localparam int N = 2**SEL_W;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
    if (SEL_W != XFER_SEL_W) begin : g_sel_w_check
        $error("SEL_W must match bridge_pkg::XFER_SEL_W");
    end
    xfer_state_t state_q, state_d;
    xfer_req_t cur_q, cur_d, head;
    logic full, empty, pop;
    logic goe_d, dir_d, done_d;
    logic [N-1:0] src_oe_d, dst_ld_d;
    assign req_ready = !full;
    assign busy = state_q != IDLE || !empty;
    bridge_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(req_valid && req_ready),
        .pop(pop),
        .wr_data('{dir: req_dir, src: req_src, dst: req_dst}),
        .rd_data(head),
        .full(full),
        .empty(empty)
    );
    // next state and next registered outputs; Dir keeps its last value in IDLE
    always_comb begin
        pop = !empty && state_q != DRIVE;
        state_d = state_q == DRIVE ? LATCH : pop ? DRIVE : IDLE;
        cur_d = pop ? head : cur_q;
        goe_d = state_d != IDLE;
        dir_d = state_d == IDLE ? Dir : cur_d.dir == DIR_DOWN;
        src_oe_d = state_d == IDLE ? '0 : ONE << cur_d.src;
        dst_ld_d = state_d == LATCH ? ONE << cur_d.dst : '0;
        done_d = state_d == LATCH;
    end
    // state, transfer register and all control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q <= '0;
            GOe <= 1'b0;
            Dir <= DIR_UP;
            src_oe <= '0;
            dst_ld <= '0;
            xfer_done <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q <= cur_d;
            GOe <= goe_d;
            Dir <= dir_d;
            src_oe <= src_oe_d;
            dst_ld <= dst_ld_d;
            xfer_done <= done_d;
        end
    end
`ifdef BRIDGE_XFER_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    assign xfer_cnt = cnt_q;
    // completed-transfer counter, wraps at 2**CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (xfer_done) cnt_q <= cnt_q + 1'b1;
    end
`else
    assign xfer_cnt = '0;
`endif
endmodule

// File: tb/tb_bridge_xfer_ctrl.sv
// tb_bridge_xfer_ctrl: directed self-checking bench for bridge_xfer_ctrl
module tb_bridge_xfer_ctrl;
    import bridge_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_dir = 1'b0;
    logic [2:0] req_src = '0;
    logic [2:0] req_dst = '0;
    logic req_ready, GOe, Dir, xfer_done, busy;
    logic [7:0] src_oe, dst_ld;
    logic [3:0] xfer_cnt;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc[$];
    logic [7:0] done_dst[$];
    int stalls, fc, snap;

    bridge_xfer_ctrl #(.SEL_W(3), .FIFO_DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_dir(req_dir), .req_src(req_src), .req_dst(req_dst),
        .GOe(GOe), .Dir(Dir), .src_oe(src_oe), .dst_ld(dst_ld),
        .xfer_done(xfer_done), .busy(busy), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (xfer_done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            done_dst.push_back(dst_ld);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        done_cnt = 0;
        done_cyc.delete();
        done_dst.delete();
    endtask

    task automatic push_seq(input int n, output int st, output int first);
        st = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            req_valid = 1'b1;
            req_dir = i[0];
            req_src = 3'(7 - i);
            req_dst = 3'(i);
            while (!req_ready && guard < 50) begin
                st++;
                guard++;
                step();
            end
            chk("push_bound", 32'(guard < 50), 1);
            if (first < 0) first = cyc + 1;
            step();
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_cnt < n && k < 300) begin
            step();
            k++;
        end
        chk("wait_done", done_cnt, n);
    endtask

    task automatic single(input logic d, input logic [2:0] s, input logic [2:0] t);
        req_valid = 1'b1;
        req_dir = d;
        req_src = s;
        req_dst = t;
        step();
        req_valid = 1'b0;
        chk("acc_busy", busy, 1);
        chk("acc_goe", GOe, 0);
        step();
        chk("drv_goe", GOe, 1);
        chk("drv_dir", Dir, d);
        chk("drv_src_oe", src_oe, 32'd1 << s);
        chk("drv_dst_ld", dst_ld, 0);
        chk("drv_done", xfer_done, 0);
        step();
        chk("lat_goe", GOe, 1);
        chk("lat_src_oe", src_oe, 32'd1 << s);
        chk("lat_dst_ld", dst_ld, 32'd1 << t);
        chk("lat_done", xfer_done, 1);
        step();
        chk("idle_busy", busy, 0);
        chk("idle_goe", GOe, 0);
        chk("idle_dir_hold", Dir, d);
        chk("idle_src_oe", src_oe, 0);
        chk("idle_dst_ld", dst_ld, 0);
        chk("idle_done", xfer_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_goe", GOe, 0);
        chk("rst_dir", Dir, 0);
        chk("rst_src_oe", src_oe, 0);
        chk("rst_dst_ld", dst_ld, 0);
        chk("rst_done", xfer_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", xfer_cnt, 0);
        chk("rst_ready", req_ready, 1);

        single(DIR_DOWN, 3'd2, 3'd5);
        single(DIR_UP, 3'd0, 3'd7);

        do_reset();
        push_seq(4, stalls, fc);
        chk("b2b_stalls", stalls, 0);
        wait_done(4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b2b_done_cyc%0d", k), done_cyc[k], fc + 2 + 2 * k);
            chk($sformatf("b2b_dst%0d", k), done_dst[k], 32'd1 << k);
        end
`ifdef BRIDGE_XFER_CNT_EN
        chk("b2b_cnt", xfer_cnt, 4);
`else
        chk("b2b_cnt", xfer_cnt, 0);
`endif

        do_reset();
        push_seq(8, stalls, fc);
        chk("full_stalls", stalls, 1);
        wait_done(8);
        for (int k = 0; k < 8; k++) chk($sformatf("full_order%0d", k), done_dst[k], 32'd1 << k);

        do_reset();
        push_seq(4, stalls, fc);
        chk("pre_rst_goe", GOe, 1);
        chk("pre_rst_src_oe", src_oe, 32'h40);
        chk("pre_rst_busy", busy, 1);
        snap = done_cnt;
        rst = 1'b1;
        #1;
        chk("arst_goe", GOe, 0);
        chk("arst_dir", Dir, 0);
        chk("arst_src_oe", src_oe, 0);
        chk("arst_dst_ld", dst_ld, 0);
        chk("arst_done", xfer_done, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", req_ready, 1);
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("arst_no_done", done_cnt, snap);
        chk("arst_idle_busy", busy, 0);

        do_reset();
        push_seq(17, stalls, fc);
        wait_done(17);
        repeat (2) step();
`ifdef BRIDGE_XFER_CNT_EN
        chk("cnt_wrap", xfer_cnt, 1);
`else
        chk("cnt_tied", xfer_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
